// File: rtl/ahb_slave_port_arbiter_pkg.sv
// Shared AHB types and helpers for the slave-port arbiter.
// Burst length decode lives here so the interconnect can reuse it.
package ahb_slave_port_arbiter_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    BURST = 2'd1,
    LOCK  = 2'd2
  } arb_state_e;

  // Beats left after the NONSEQ; 0 means open-ended INCR.
  function automatic logic [3:0] burst_beats(input hburst_e hb);
    unique case (hb)
      HB_WRAP4,  HB_INCR4:  burst_beats = 4'd3;
      HB_WRAP8,  HB_INCR8:  burst_beats = 4'd7;
      HB_WRAP16, HB_INCR16: burst_beats = 4'd15;
      default:              burst_beats = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slave_port_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after i_ptr, with wrap.
// Pure combinational; one-hot grant plus index.
module ahb_slave_port_arbiter_rr_picker #(
  parameter int N      = 4,
  parameter int MIDX_W = $clog2(N)
) (
  input  logic [N-1:0]      i_req,
  input  logic [MIDX_W-1:0] i_ptr,
  output logic [N-1:0]      o_gnt,
  output logic [MIDX_W-1:0] o_idx,
  output logic              o_vld
);

  logic [MIDX_W-1:0] w_k;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    w_k   = '0;
    for (int i = 0; i < N; i++) begin
      w_k = MIDX_W'((int'(i_ptr) + i) % N);
      if (!o_vld && i_req[w_k]) begin
        o_gnt[w_k] = 1'b1;
        o_idx      = w_k;
        o_vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_slave_port_arbiter.sv
// Per-slave AHB arbiter: round-robin with lock priority and burst hold.
// Tracks address-phase and data-phase owners for the interconnect muxes.
module ahb_slave_port_arbiter
  import ahb_slave_port_arbiter_pkg::*;
#(
  parameter int NO_OF_MASTERS = 4,
  parameter int MIDX_W        = $clog2(NO_OF_MASTERS)
) (
  input  logic                       hclk,
  input  logic                       hresetn,
  input  logic [NO_OF_MASTERS-1:0]   req_i,
  input  logic [2*NO_OF_MASTERS-1:0] htrans_i,
  input  logic [3*NO_OF_MASTERS-1:0] hburst_i,
  input  logic [NO_OF_MASTERS-1:0]   hmastlock_i,
  input  logic                       hready_i,
  output logic [NO_OF_MASTERS-1:0]   grant_o,
  output logic [MIDX_W-1:0]          aphase_owner_o,
  output logic                       aphase_valid_o,
  output logic [MIDX_W-1:0]          dphase_owner_o,
  output logic                       dphase_valid_o,
  output logic                       locked_o
);

  arb_state_e          r_state;
  logic [MIDX_W-1:0]   r_rr_ptr;
  logic [MIDX_W-1:0]   r_owner;
  logic [3:0]          r_beat_cnt;
  logic [MIDX_W-1:0]   r_dph_owner;
  logic                r_dph_valid;

  htrans_e             w_trans [NO_OF_MASTERS];
  hburst_e             w_burst [NO_OF_MASTERS];
  logic [NO_OF_MASTERS-1:0] w_lreq;
  logic [NO_OF_MASTERS-1:0] w_lgnt;
  logic [NO_OF_MASTERS-1:0] w_pgnt;
  logic [NO_OF_MASTERS-1:0] w_sel_gnt;
  logic [NO_OF_MASTERS-1:0] w_own_gnt;
  logic [MIDX_W-1:0]   w_lidx;
  logic [MIDX_W-1:0]   w_pidx;
  logic [MIDX_W-1:0]   w_sel_idx;
  logic [MIDX_W-1:0]   w_next_ptr;
  logic                w_lvld;
  logic                w_pvld;
  logic                w_sel_vld;
  htrans_e             w_own_trans;
  logic                w_burst_rel;
  logic                w_lock_rel;
  logic                w_arb;

  for (genvar m = 0; m < NO_OF_MASTERS; m++) begin : g_unpack
    assign w_trans[m] = htrans_e'(htrans_i[2*m +: 2]);
    assign w_burst[m] = hburst_e'(hburst_i[3*m +: 3]);
  end

  assign w_lreq = req_i & hmastlock_i;

  ahb_slave_port_arbiter_rr_picker #(
    .N      (NO_OF_MASTERS),
    .MIDX_W (MIDX_W)
  ) u_lock_pick (
    .i_req (w_lreq),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_lgnt),
    .o_idx (w_lidx),
    .o_vld (w_lvld)
  );

  ahb_slave_port_arbiter_rr_picker #(
    .N      (NO_OF_MASTERS),
    .MIDX_W (MIDX_W)
  ) u_plain_pick (
    .i_req (req_i),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pgnt),
    .o_idx (w_pidx),
    .o_vld (w_pvld)
  );

  assign w_sel_gnt = w_lvld ? w_lgnt : w_pgnt;
  assign w_sel_idx = w_lvld ? w_lidx : w_pidx;
  assign w_sel_vld = w_lvld | w_pvld;

  assign w_own_trans = w_trans[r_owner];

  // Holding owners give up the slave the same cycle they stop the sequence.
  assign w_burst_rel = (r_state == BURST) &&
                       (w_own_trans == HT_IDLE ||
                        w_own_trans == HT_NONSEQ);
  assign w_lock_rel  = (r_state == LOCK) &&
                       !hmastlock_i[r_owner] &&
                       (w_own_trans == HT_IDLE ||
                        w_own_trans == HT_NONSEQ);
  assign w_arb = (r_state == ARB) || w_burst_rel || w_lock_rel;

  always_comb begin
    w_own_gnt          = '0;
    w_own_gnt[r_owner] = 1'b1;
  end

  assign grant_o        = w_arb ? w_sel_gnt : w_own_gnt;
  assign aphase_owner_o = w_arb ? w_sel_idx : r_owner;
  assign aphase_valid_o = w_arb ? w_sel_vld : 1'b1;

  assign w_next_ptr = (w_sel_idx == MIDX_W'(NO_OF_MASTERS - 1)) ?
                      '0 : w_sel_idx + 1'b1;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state     <= ARB;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_beat_cnt  <= '0;
      r_dph_owner <= '0;
      r_dph_valid <= 1'b0;
    end else if (hready_i) begin
      r_dph_owner <= aphase_owner_o;
      r_dph_valid <= aphase_valid_o;
      if (w_arb) begin
        if (w_sel_vld) begin
          r_owner  <= w_sel_idx;
          r_rr_ptr <= w_next_ptr;
          if (hmastlock_i[w_sel_idx]) begin
            r_state    <= LOCK;
            r_beat_cnt <= '0;
          end else if (w_trans[w_sel_idx] == HT_NONSEQ &&
                       w_burst[w_sel_idx] != HB_SINGLE) begin
            r_state    <= BURST;
            r_beat_cnt <= burst_beats(w_burst[w_sel_idx]);
          end else begin
            r_state    <= ARB;
            r_beat_cnt <= '0;
          end
        end else begin
          r_state    <= ARB;
          r_beat_cnt <= '0;
        end
      end else if (r_state == BURST && w_own_trans == HT_SEQ) begin
        if (r_beat_cnt > 4'd1) begin
          r_beat_cnt <= r_beat_cnt - 4'd1;
        end else if (r_beat_cnt == 4'd1) begin
          r_state    <= ARB;
          r_beat_cnt <= '0;
        end
      end
    end
  end

  assign dphase_owner_o = r_dph_owner;
  assign dphase_valid_o = r_dph_valid;
  assign locked_o       = (r_state == LOCK);

endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
// Directed vector bench for the AHB slave-port arbiter.
// Table of per-cycle stimulus plus a reset-mid-burst sequence.
module tb_ahb_slave_port_arbiter;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [3:0]  req_i;
  logic [7:0]  htrans_i;
  logic [11:0] hburst_i;
  logic [3:0]  hmastlock_i;
  logic        hready_i;
  logic [3:0]  grant_o;
  logic [1:0]  aphase_owner_o;
  logic        aphase_valid_o;
  logic [1:0]  dphase_owner_o;
  logic        dphase_valid_o;
  logic        locked_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 hclk = ~hclk;

  ahb_slave_port_arbiter #(
    .NO_OF_MASTERS (4)
  ) dut (
    .hclk           (hclk),
    .hresetn        (hresetn),
    .req_i          (req_i),
    .htrans_i       (htrans_i),
    .hburst_i       (hburst_i),
    .hmastlock_i    (hmastlock_i),
    .hready_i       (hready_i),
    .grant_o        (grant_o),
    .aphase_owner_o (aphase_owner_o),
    .aphase_valid_o (aphase_valid_o),
    .dphase_owner_o (dphase_owner_o),
    .dphase_valid_o (dphase_valid_o),
    .locked_o       (locked_o)
  );

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  tr;
    logic [11:0] hb;
    logic [3:0]  lk;
    logic        rdy;
    logic [3:0]  g;
    logic [1:0]  dpo;
    logic        dpv;
    logic        lkd;
    logic        cb;
    logic [3:0]  bc;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t v(
    input logic [3:0] req, input logic [7:0] tr,
    input logic [11:0] hb, input logic [3:0] lk,
    input logic rdy, input logic [3:0] g,
    input logic [1:0] dpo, input logic dpv,
    input logic lkd, input logic cb, input logic [3:0] bc);
    vec_t r;
    r.req = req; r.tr = tr; r.hb = hb; r.lk = lk;
    r.rdy = rdy; r.g = g; r.dpo = dpo; r.dpv = dpv;
    r.lkd = lkd; r.cb = cb; r.bc = bc;
    return r;
  endfunction

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (g[k]) r = 2'(k);
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic [7:0] tr,
                       input logic [11:0] hb, input logic [3:0] lk,
                       input logic rdy);
    req_i = req; htrans_i = tr; hburst_i = hb;
    hmastlock_i = lk; hready_i = rdy;
  endtask

  localparam logic [11:0] M0I4  = 12'b000_000_000_011;
  localparam logic [11:0] M1I4  = 12'b000_000_011_000;
  localparam logic [11:0] M1I8  = 12'b000_000_101_000;
  localparam logic [11:0] M2I16 = 12'b000_111_000_000;

  initial begin
    // round-robin rotation with SINGLE transfers
    tbl.push_back(v(4'b1010, 8'b10_00_10_00, 0, 0, 1, 4'b0010, 0, 0, 0, 0, 0));
    tbl.push_back(v(4'b1010, 8'b10_00_10_00, 0, 0, 1, 4'b1000, 1, 1, 0, 0, 0));
    tbl.push_back(v(4'b1010, 8'b10_00_10_00, 0, 0, 1, 4'b0010, 3, 1, 0, 0, 0));
    tbl.push_back(v(4'b0000, 8'b00_00_00_00, 0, 0, 1, 4'b0000, 1, 1, 0, 0, 0));
    tbl.push_back(v(4'b1000, 8'b10_00_00_00, 0, 0, 1, 4'b1000, 0, 0, 0, 0, 0));
    // M0 INCR4 while M2 waits
    tbl.push_back(v(4'b0101, 8'b00_10_00_10, M0I4, 0, 1, 4'b0001, 3, 1, 0, 1, 0));
    tbl.push_back(v(4'b0101, 8'b00_10_00_11, M0I4, 0, 1, 4'b0001, 0, 1, 0, 1, 3));
    tbl.push_back(v(4'b0101, 8'b00_10_00_11, M0I4, 0, 1, 4'b0001, 0, 1, 0, 1, 2));
    tbl.push_back(v(4'b0101, 8'b00_10_00_11, M0I4, 0, 1, 4'b0001, 0, 1, 0, 1, 1));
    tbl.push_back(v(4'b0100, 8'b00_10_00_00, 0, 0, 1, 4'b0100, 0, 1, 0, 1, 0));
    tbl.push_back(v(4'b0000, 8'b00_00_00_00, 0, 0, 1, 4'b0000, 2, 1, 0, 0, 0));
    // M1 INCR4 with three wait states after beat 2
    tbl.push_back(v(4'b0110, 8'b00_10_10_00, M1I4, 0, 1, 4'b0010, 0, 0, 0, 0, 0));
    tbl.push_back(v(4'b0110, 8'b00_10_11_00, M1I4, 0, 1, 4'b0010, 1, 1, 0, 1, 3));
    tbl.push_back(v(4'b0110, 8'b00_10_11_00, M1I4, 0, 0, 4'b0010, 1, 1, 0, 1, 2));
    tbl.push_back(v(4'b0110, 8'b00_10_11_00, M1I4, 0, 0, 4'b0010, 1, 1, 0, 1, 2));
    tbl.push_back(v(4'b0110, 8'b00_10_11_00, M1I4, 0, 0, 4'b0010, 1, 1, 0, 1, 2));
    tbl.push_back(v(4'b0110, 8'b00_10_11_00, M1I4, 0, 1, 4'b0010, 1, 1, 0, 1, 2));
    tbl.push_back(v(4'b0110, 8'b00_10_11_00, M1I4, 0, 1, 4'b0010, 1, 1, 0, 1, 1));
    tbl.push_back(v(4'b0100, 8'b00_10_00_00, 0, 0, 1, 4'b0100, 1, 1, 0, 1, 0));
    tbl.push_back(v(4'b0000, 8'b00_00_00_00, 0, 0, 1, 4'b0000, 2, 1, 0, 0, 0));
    // park rr_ptr at 0, then locked M3 beats M0/M1
    tbl.push_back(v(4'b1000, 8'b10_00_00_00, 0, 0, 1, 4'b1000, 0, 0, 0, 0, 0));
    tbl.push_back(v(4'b0000, 8'b00_00_00_00, 0, 0, 1, 4'b0000, 3, 1, 0, 0, 0));
    tbl.push_back(v(4'b1011, 8'b10_00_10_10, 0, 4'b1000, 1, 4'b1000, 0, 0, 0, 0, 0));
    tbl.push_back(v(4'b1011, 8'b10_00_10_10, 0, 4'b1000, 1, 4'b1000, 3, 1, 1, 0, 0));
    tbl.push_back(v(4'b0011, 8'b00_00_10_10, 0, 4'b1000, 1, 4'b1000, 3, 1, 1, 0, 0));
    tbl.push_back(v(4'b0011, 8'b00_00_10_10, 0, 4'b0000, 1, 4'b0001, 3, 1, 1, 0, 0));
    tbl.push_back(v(4'b0011, 8'b00_00_10_10, 0, 4'b0000, 1, 4'b0010, 0, 1, 0, 0, 0));
    tbl.push_back(v(4'b0000, 8'b00_00_00_00, 0, 0, 1, 4'b0000, 1, 1, 0, 0, 0));
    // M2 INCR16 cut short by IDLE after 5 beats, M0 pending
    tbl.push_back(v(4'b0101, 8'b00_10_00_10, M2I16, 0, 1, 4'b0100, 0, 0, 0, 0, 0));
    tbl.push_back(v(4'b0101, 8'b00_11_00_10, M2I16, 0, 1, 4'b0100, 2, 1, 0, 1, 15));
    tbl.push_back(v(4'b0101, 8'b00_11_00_10, M2I16, 0, 1, 4'b0100, 2, 1, 0, 1, 14));
    tbl.push_back(v(4'b0101, 8'b00_11_00_10, M2I16, 0, 1, 4'b0100, 2, 1, 0, 1, 13));
    tbl.push_back(v(4'b0101, 8'b00_11_00_10, M2I16, 0, 1, 4'b0100, 2, 1, 0, 1, 12));
    tbl.push_back(v(4'b0001, 8'b00_00_00_10, M2I16, 0, 1, 4'b0001, 2, 1, 0, 1, 11));
    tbl.push_back(v(4'b0000, 8'b00_00_00_00, 0, 0, 1, 4'b0000, 0, 1, 0, 1, 0));

    hresetn = 1'b0;
    drive(0, 0, 0, 0, 1);
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;
    #1;
    chk("rst grant", 32'(grant_o), 0);
    chk("rst aval", 32'(aphase_valid_o), 0);
    chk("rst dpo", 32'(dphase_owner_o), 0);
    chk("rst dpv", 32'(dphase_valid_o), 0);
    chk("rst locked", 32'(locked_o), 0);
    chk("rst beat", 32'(dut.r_beat_cnt), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge hclk);
      #1 drive(tbl[i].req, tbl[i].tr, tbl[i].hb, tbl[i].lk, tbl[i].rdy);
      #1;
      chk($sformatf("v%0d grant", i), 32'(grant_o), 32'(tbl[i].g));
      chk($sformatf("v%0d aown", i), 32'(aphase_owner_o),
          32'(idx_of(tbl[i].g)));
      chk($sformatf("v%0d aval", i), 32'(aphase_valid_o),
          32'(|tbl[i].g));
      chk($sformatf("v%0d dpo", i), 32'(dphase_owner_o), 32'(tbl[i].dpo));
      chk($sformatf("v%0d dpv", i), 32'(dphase_valid_o), 32'(tbl[i].dpv));
      chk($sformatf("v%0d locked", i), 32'(locked_o), 32'(tbl[i].lkd));
      if (tbl[i].cb)
        chk($sformatf("v%0d beat", i), 32'(dut.r_beat_cnt), 32'(tbl[i].bc));
    end

    // M1 INCR8 (rr_ptr=1), reset asserted between edges mid-burst
    @(posedge hclk);
    #1 drive(4'b0010, 8'b00_00_10_00, M1I8, 0, 1);
    #1 chk("i8 grant0", 32'(grant_o), 32'h2);
    @(posedge hclk);
    #1 drive(4'b0010, 8'b00_00_11_00, M1I8, 0, 1);
    #1 chk("i8 beat7", 32'(dut.r_beat_cnt), 7);
    @(posedge hclk);
    #2;
    chk("i8 beat6", 32'(dut.r_beat_cnt), 6);
    chk("i8 dpv", 32'(dphase_valid_o), 1);
    chk("i8 dpo", 32'(dphase_owner_o), 1);
    #1 hresetn = 1'b0;
    drive(0, 0, 0, 0, 1);
    #1;
    chk("arst grant", 32'(grant_o), 0);
    chk("arst aval", 32'(aphase_valid_o), 0);
    chk("arst dpo", 32'(dphase_owner_o), 0);
    chk("arst dpv", 32'(dphase_valid_o), 0);
    chk("arst locked", 32'(locked_o), 0);
    chk("arst beat", 32'(dut.r_beat_cnt), 0);
    @(posedge hclk);
    #1 hresetn = 1'b1;
    drive(4'b1010, 8'b10_00_10_00, 0, 0, 1);
    #1 chk("post-rst grant", 32'(grant_o), 32'h2);
    chk("post-rst aown", 32'(aphase_owner_o), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
